// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, write ports and the issue strobe.
// Packed vectors are declared descending, but the datapath numbers bits
// MSB-first: spec bit i of a W-bit field is vector bit [W-1-i], so port k of
// a packed group sits in the k-th field counted from the most significant end.
interface reg_file_mp_if #(
   parameter int DW  = 64,
   parameter int AW  = 6,
   parameter int NRD = 2,
   parameter int NWR = 2
) ();
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic [NWR-1:0]    wr_en;
   logic [NWR*3-1:0]  wr_ppp;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;

   // decode/writeback side
   modport master (
      output rd_addr, wr_en, wr_ppp, wr_addr, wr_data, iss_en, iss_addr,
      input  rd_data, rd_busy
   );

   // register file side
   modport slave (
      input  rd_addr, wr_en, wr_ppp, wr_addr, wr_data, iss_en, iss_addr,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with hardwired R0,
// lane-selected (ppp) partial writes, lane-accurate write-to-read forwarding
// and an optional RAW scoreboard.
// Optional feature macro: RF_SCOREBOARD_EN (busy tracking and rd_busy).
// Bit numbering is MSB-first: datapath bit i lives at vector bit [DW-1-i];
// port k of a packed group is the k-th field from the most significant end.
module reg_file_mp #(
   parameter int DW   = 64,
   parameter int NREG = 32,
   parameter int AW   = 6,
   parameter int NRD  = 2,
   parameter int NWR  = 2
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_mp_if.slave  bus
);

   // Lane mask for a ppp code; an invalid code gives an empty mask.
   function automatic logic [DW-1:0] lane_mask(input logic [2:0] ppp);
      logic [DW-1:0] m;
      m = '0;
      for (int i = 0; i < DW; i++) begin
         case (ppp)
            3'b000:  m[DW-1-i] = 1'b1;
            3'b001:  m[DW-1-i] = (i < DW/2);
            3'b010:  m[DW-1-i] = (i >= DW/2);
            3'b011:  m[DW-1-i] = (((i/8) % 2) == 0);
            3'b100:  m[DW-1-i] = (((i/8) % 2) == 1);
            default: m[DW-1-i] = 1'b0;
         endcase
      end
      return m;
   endfunction

   // Bitwise merge of new data into old under a mask.
   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [DW-1:0] m);
      return (old_v & ~m) | (new_v & m);
   endfunction

   logic [DW-1:0] regs_q [1:NREG-1];
   logic [DW-1:0] regs_d [1:NREG-1];

   logic [AW-1:0] wa_s [NWR];
   logic [DW-1:0] wd_s [NWR];
   logic [DW-1:0] wm_s [NWR];   // effective mask, zero when the port is idle
   logic [AW-1:0] ra_s [NRD];
   logic          rv_s [NRD];   // read address names a real, non-zero register
   logic [DW-1:0] rfwd_s [NRD];
   logic [NRD*DW-1:0] rd_data_s;
   logic [NRD-1:0]    rd_busy_s;

   // Unpack write ports; a disabled port contributes an empty mask.
   always_comb begin
      for (int p = 0; p < NWR; p++) begin
         wa_s[p] = bus.wr_addr[(NWR-1-p)*AW +: AW];
         wd_s[p] = bus.wr_data[(NWR-1-p)*DW +: DW];
         wm_s[p] = bus.wr_en[NWR-1-p] ? lane_mask(bus.wr_ppp[(NWR-1-p)*3 +: 3])
                                      : {DW{1'b0}};
      end
   end

   // Next register contents: ports applied in ascending order so the highest
   // index wins overlapping bits; R0 and out-of-range addresses match nothing.
   always_comb begin
      for (int r = 1; r < NREG; r++) begin
         regs_d[r] = regs_q[r];
         for (int p = 0; p < NWR; p++) begin
            regs_d[r] = (wa_s[p] == AW'(r)) ? merge(regs_d[r], wd_s[p], wm_s[p])
                                            : regs_d[r];
         end
      end
   end

   // Register storage with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 1; r < NREG; r++) begin
            regs_q[r] <= {DW{1'b0}};
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Combinational reads: stored value overlaid per bit with same-cycle writes.
   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         ra_s[k]   = bus.rd_addr[(NRD-1-k)*AW +: AW];
         rv_s[k]   = (ra_s[k] != {AW{1'b0}}) && ({1'b0, ra_s[k]} < (AW+1)'(NREG));
         rfwd_s[k] = {DW{1'b0}};
         for (int r = 1; r < NREG; r++) begin
            rfwd_s[k] = (ra_s[k] == AW'(r)) ? regs_q[r] : rfwd_s[k];
         end
         for (int p = 0; p < NWR; p++) begin
            rfwd_s[k] = (ra_s[k] == wa_s[p]) ? merge(rfwd_s[k], wd_s[p], wm_s[p])
                                             : rfwd_s[k];
         end
         rd_data_s[(NRD-1-k)*DW +: DW] = (rst && rv_s[k]) ? rfwd_s[k] : {DW{1'b0}};
      end
   end

   assign bus.rd_data = rd_data_s;

`ifdef RF_SCOREBOARD_EN
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] set_s;
   logic [NREG-1:0] clr_s;

   // Per-register set (issue) and clear (any valid-lane writeback) strobes.
   always_comb begin
      set_s[0] = 1'b0;
      clr_s[0] = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         set_s[r] = bus.iss_en && (bus.iss_addr == AW'(r));
         clr_s[r] = 1'b0;
         for (int p = 0; p < NWR; p++) begin
            clr_s[r] = clr_s[r] | ((wa_s[p] == AW'(r)) && (wm_s[p] != {DW{1'b0}}));
         end
      end
   end

   // Set dominates clear: a new producer supersedes the completing one.
   always_comb begin
      busy_d = (busy_q & ~clr_s) | set_s;
   end

   // Busy vector with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= {NREG{1'b0}};
      end else begin
         busy_q <= busy_d;
      end
   end

   // A completing writeback hides busy from a same-cycle reader.
   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         rd_busy_s[NRD-1-k] = 1'b0;
         for (int r = 1; r < NREG; r++) begin
            rd_busy_s[NRD-1-k] = (ra_s[k] == AW'(r)) ? (busy_q[r] & ~clr_s[r])
                                                     : rd_busy_s[NRD-1-k];
         end
         rd_busy_s[NRD-1-k] = rd_busy_s[NRD-1-k] & rst;
      end
   end
`else
   logic unused_iss_s;

   // Scoreboard compiled out: no busy state, issue inputs have no effect.
   always_comb begin
      rd_busy_s    = {NRD{1'b0}};
      unused_iss_s = ^{bus.iss_en, bus.iss_addr};
   end
`endif

   assign bus.rd_busy = rd_busy_s;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios followed by random
// traffic, all compared against a word/lane-level reference model.
module tb_reg_file_mp;
   localparam int DW   = 64;
   localparam int NREG = 32;
   localparam int AW   = 6;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
`ifdef RF_SCOREBOARD_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic clk;
   logic rst;

   reg_file_mp_if #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR)) bus_if ();

   reg_file_mp #(.DW(DW), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stimulus, index = port number
   logic        t_wen   [NWR];
   logic [2:0]  t_ppp   [NWR];
   logic [5:0]  t_waddr [NWR];
   logic [63:0] t_wdata [NWR];
   logic [5:0]  t_raddr [NRD];
   logic        t_iss;
   logic [5:0]  t_iss_addr;

   // reference model
   logic [63:0] m_mem  [NREG];
   logic        m_busy [NREG];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Lane masks as whole-word constants; byte 0 is the most significant byte.
   function automatic logic [63:0] lane_of(input logic [2:0] ppp);
      case (ppp)
         3'd0:    return 64'hFFFF_FFFF_FFFF_FFFF;
         3'd1:    return 64'hFFFF_FFFF_0000_0000;
         3'd2:    return 64'h0000_0000_FFFF_FFFF;
         3'd3:    return 64'hFF00_FF00_FF00_FF00;
         3'd4:    return 64'h00FF_00FF_00FF_00FF;
         default: return 64'h0;
      endcase
   endfunction

   function automatic logic [63:0] exp_read(input logic [5:0] a);
      logic [63:0] v;
      logic [63:0] m;
      if (!rst || a == 6'd0 || a >= NREG) return 64'h0;
      v = m_mem[a];
      for (int p = 0; p < NWR; p++) begin
         if (t_wen[p] && t_waddr[p] == a) begin
            m = lane_of(t_ppp[p]);
            v = (v & ~m) | (t_wdata[p] & m);
         end
      end
      return v;
   endfunction

   function automatic logic exp_busy(input logic [5:0] a);
      logic b;
      if (!SB || !rst || a == 6'd0 || a >= NREG) return 1'b0;
      b = m_busy[a];
      for (int p = 0; p < NWR; p++)
         if (t_wen[p] && lane_of(t_ppp[p]) != 64'h0 && t_waddr[p] == a) b = 1'b0;
      return b;
   endfunction

   task automatic model_clock();
      if (!rst) begin
         for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = 64'h0;
            m_busy[r] = 1'b0;
         end
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (t_wen[p] && t_waddr[p] != 6'd0 && t_waddr[p] < NREG) begin
               m_mem[t_waddr[p]] = (m_mem[t_waddr[p]] & ~lane_of(t_ppp[p])) |
                                   (t_wdata[p] & lane_of(t_ppp[p]));
               if (lane_of(t_ppp[p]) != 64'h0) m_busy[t_waddr[p]] = 1'b0;
            end
         end
         if (t_iss && t_iss_addr != 6'd0 && t_iss_addr < NREG) m_busy[t_iss_addr] = 1'b1;
      end
   endtask

   task automatic idle();
      for (int p = 0; p < NWR; p++) begin
         t_wen[p] = 1'b0; t_ppp[p] = 3'd0; t_waddr[p] = 6'd0; t_wdata[p] = 64'h0;
      end
      for (int k = 0; k < NRD; k++) t_raddr[k] = 6'd0;
      t_iss = 1'b0; t_iss_addr = 6'd0;
   endtask

   task automatic drive();
      bus_if.wr_en    = {t_wen[0], t_wen[1]};
      bus_if.wr_ppp   = {t_ppp[0], t_ppp[1]};
      bus_if.wr_addr  = {t_waddr[0], t_waddr[1]};
      bus_if.wr_data  = {t_wdata[0], t_wdata[1]};
      bus_if.rd_addr  = {t_raddr[0], t_raddr[1]};
      bus_if.iss_en   = t_iss;
      bus_if.iss_addr = t_iss_addr;
   endtask

   function automatic logic [63:0] rd(input int k);
      return bus_if.rd_data[(NRD-1-k)*DW +: DW];
   endfunction

   function automatic logic [63:0] bz(input int k);
      return {63'h0, bus_if.rd_busy[NRD-1-k]};
   endfunction

   // Drive, check all read ports against the model, then take one clock.
   task automatic step();
      drive();
      #2;
      for (int k = 0; k < NRD; k++) begin
         check_val($sformatf("model_rd%0d_a%0d", k, t_raddr[k]), rd(k), exp_read(t_raddr[k]));
         check_val($sformatf("model_busy%0d_a%0d", k, t_raddr[k]), bz(k), {63'h0, exp_busy(t_raddr[k])});
      end
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic wr(input int p, input logic [5:0] a, input logic [2:0] ppp, input logic [63:0] d);
      t_wen[p] = 1'b1; t_waddr[p] = a; t_ppp[p] = ppp; t_wdata[p] = d;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      for (int r = 0; r < NREG; r++) begin m_mem[r] = 64'h0; m_busy[r] = 1'b0; end
      drive();
      @(negedge clk);

      // reset holds outputs at zero and ignores writes
      wr(0, 6'd5, 3'd0, 64'h1234_5678_9ABC_DEF0); t_raddr[0] = 6'd5;
      t_iss = 1'b1; t_iss_addr = 6'd5; t_raddr[1] = 6'd5;
      drive(); #2;
      check_val("in_rst_rd", rd(0), 64'h0);
      check_val("in_rst_busy", bz(1), 64'h0);
      step();
      rst = 1'b1; idle(); t_raddr[0] = 6'd5; t_raddr[1] = 6'd5;
      drive(); #2;
      check_val("rst_wr_ignored", rd(0), 64'h0);
      check_val("rst_iss_ignored", bz(1), 64'h0);
      step();

      // R5 stored, then mid-run reset clears it
      wr(0, 6'd5, 3'd0, 64'hDEAD_BEEF_0123_4567); step();
      idle(); t_raddr[0] = 6'd5; drive(); #2;
      check_val("r5_stored", rd(0), 64'hDEAD_BEEF_0123_4567);
      step();
      rst = 1'b0; drive(); #2;
      check_val("mid_rst_r5", rd(0), 64'h0);
      step();
      rst = 1'b1; drive(); #2;
      check_val("post_rst_r5", rd(0), 64'h0);
      step();

      // R0 is hardwired
      wr(0, 6'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF); t_raddr[0] = 6'd0; t_raddr[1] = 6'd0;
      drive(); #2;
      check_val("r0_fwd0", rd(0), 64'h0);
      check_val("r0_fwd1", rd(1), 64'h0);
      step();
      idle(); drive(); #2;
      check_val("r0_stored", rd(0), 64'h0);
      step();

      // partial even-byte write with forwarding
      wr(0, 6'd3, 3'd0, 64'h1111_2222_3333_4444); step();
      idle(); wr(0, 6'd3, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA); t_raddr[1] = 6'd3;
      drive(); #2;
      check_val("partial_fwd", rd(1), 64'hAA11_AA22_AA33_AA44);
      step();
      idle(); t_raddr[0] = 6'd3; drive(); #2;
      check_val("partial_stored", rd(0), 64'hAA11_AA22_AA33_AA44);
      step();

      // dual-port same-address merge, port 1 wins
      wr(0, 6'd7, 3'd0, 64'h0); wr(1, 6'd7, 3'd1, 64'hFFFF_FFFF_0000_0000); t_raddr[1] = 6'd7;
      drive(); #2;
      check_val("dual_fwd", rd(1), 64'hFFFF_FFFF_0000_0000);
      step();
      idle(); t_raddr[0] = 6'd7; drive(); #2;
      check_val("dual_stored", rd(0), 64'hFFFF_FFFF_0000_0000);
      step();

      // scoreboard set and same-cycle clear
      t_iss = 1'b1; t_iss_addr = 6'd9; t_raddr[0] = 6'd9;
      drive(); #2;
      check_val("busy_not_yet", bz(0), 64'h0);
      step();
      idle(); t_raddr[0] = 6'd9; drive(); #2;
      check_val("busy_set", bz(0), {63'h0, SB});
      step();
      wr(1, 6'd9, 3'd2, 64'h0000_0000_CAFE_F00D); drive(); #2;
      check_val("busy_clr_same", bz(0), 64'h0);
      check_val("r9_fwd", rd(0), 64'h0000_0000_CAFE_F00D);
      step();
      idle(); t_raddr[0] = 6'd9; drive(); #2;
      check_val("busy_cleared", bz(0), 64'h0);
      step();

      // set/clear race, then invalid ppp
      idle(); t_iss = 1'b1; t_iss_addr = 6'd4; wr(0, 6'd4, 3'd0, 64'h5555_6666_7777_8888);
      step();
      idle(); t_raddr[0] = 6'd4; drive(); #2;
      check_val("race_busy", bz(0), {63'h0, SB});
      check_val("race_data", rd(0), 64'h5555_6666_7777_8888);
      step();
      wr(1, 6'd4, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF); drive(); #2;
      check_val("inv_ppp_fwd", rd(0), 64'h5555_6666_7777_8888);
      check_val("inv_ppp_busy", bz(0), {63'h0, SB});
      step();
      idle(); t_raddr[0] = 6'd4; drive(); #2;
      check_val("inv_ppp_stored", rd(0), 64'h5555_6666_7777_8888);
      check_val("inv_ppp_busy_after", bz(0), {63'h0, SB});
      step();

      // out-of-range address
      wr(0, 6'd40, 3'd0, 64'h0123_4567_89AB_CDEF); t_raddr[0] = 6'd40; drive(); #2;
      check_val("oor_fwd", rd(0), 64'h0);
      step();

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 79) != 0);
         for (int p = 0; p < NWR; p++) begin
            t_wen[p]   = $urandom_range(0, 2) != 0;
            t_ppp[p]   = 3'($urandom_range(0, 7));
            t_waddr[p] = 6'($urandom_range(0, 12) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 7));
            t_wdata[p] = {$urandom, $urandom};
         end
         for (int k = 0; k < NRD; k++)
            t_raddr[k] = ($urandom_range(0, 3) == 0) ? t_waddr[$urandom_range(0, 1)]
                                                     : 6'($urandom_range(0, 9));
         t_iss      = $urandom_range(0, 2) == 0;
         t_iss_addr = 6'($urandom_range(0, 9));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the processor's decode/writeback stages, generalising the two-read/one-write 64-bit file to configurable width, depth and port counts. It keeps hardwired R0, ppp-selected partial writeback and internal forwarding. Forwarding is lane-accurate, so a partial write forwards only the lanes it writes. An optional scoreboard tracks registers with an in-flight producer, so decode can stall on RAW hazards.

## Interface
- DW, 64: data width in bits; must be a multiple of 16.
- NREG, 32: number of registers; R0 is hardwired to zero.
- AW, 6: address width; must satisfy 2^AW >= NREG.
- NRD, 2: number of read ports.
- NWR, 2: number of write ports; higher index has higher priority.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses; port k at [k*AW : k*AW+AW-1].
- rd_data  out  NRD*DW  read data; port k at [k*DW : k*DW+DW-1].
- rd_busy  out  NRD  scoreboard busy flag per read port (scoreboard build only).
- wr_en  in  NWR  per-port write enable.
- wr_ppp  in  NWR*3  per-port lane-select code.
- wr_addr  in  NWR*AW  per-port write address.
- wr_data  in  NWR*DW  per-port write data.
- iss_en  in  1  issue strobe: marks iss_addr as having a pending producer.
- iss_addr  in  AW  destination register of the issued instruction.

## Operation
- All vectors are MSB-first, bit 0 is the MSB, matching the datapath's [0:DW-1] convention.
- The ppp code selects a lane mask for each write:
  - 000: all bits.
  - 001: [0:DW/2-1].
  - 010: [DW/2:DW-1].
  - 011: even bytes 0,2,4,… where byte b = [8b:8b+7].
  - 100: odd bytes.
  - 101–111: empty mask; no write and no busy clear.
- A write updates only the bits in its mask. Writes to address 0 or to addresses >= NREG are dropped.
- Multiple ports writing the same address in one cycle: writes merge per bit. On overlapping bits the highest-index port wins.
- Reads are combinational, built per bit:
  - If any enabled write port targets rd_addr with that bit in its mask, the bit takes that port's wr_data bit, highest index winning.
  - Otherwise the bit takes the stored value.
- A read of address 0 always returns 0, even while a write to 0 is presented. A read of an address >= NREG returns 0.
- Scoreboard: busy[NREG] bit vector; busy[0] is always 0.
  - iss_en sets busy[iss_addr].
  - Any enabled write with ppp 000, 001, 010, 011 or 100 to address A clears busy[A].
  - If set and clear target the same address in the same cycle, set wins (the new producer supersedes the old).
- rd_busy[k] = busy[rd_addr k] & ~(clear of that address this cycle). A completing writeback therefore does not stall a same-cycle reader, consistent with forwarding.

## Timing
- Write latency: data is stored at the rising edge; it is visible combinationally in the same cycle via forwarding.
- Busy set latency: busy is visible on rd_busy from the cycle after iss_en.
- Reset (rst low), asynchronous:
  - All registers clear to 0 and all busy bits clear to 0.
  - rd_data = 0 and rd_busy = 0 while rst is low, independent of addresses and writes.
  - Writes and issues presented while rst is low are ignored.
- Reset release: first write is accepted at the first rising edge with rst high.
- Mid-operation reset discards all pending busy state; no recovery sequence is required.

## Configuration
- RF_SCOREBOARD_EN defined: busy vector, iss_* logic and rd_busy are built as described above.
- RF_SCOREBOARD_EN undefined:
  - No busy state is built.
  - rd_busy is tied to 0 and iss_en/iss_addr are ignored.
  - The port list is unchanged.

## Test plan
- Reset and R0: drive rst low mid-run, then read R5 -> 0. Write R0=0xFFFF_FFFF_FFFF_FFFF ppp 000, then read R0 -> 0 on both the forwarded and the stored path.
- Partial write with forwarding: R3 holds 0x1111_2222_3333_4444. Write port 0, ppp 011, data 0xAAAA_AAAA_AAAA_AAAA. Same-cycle read -> 0xAA11_AA22_AA33_AA44; next-cycle stored value is identical.
- Dual-port conflict: same cycle, port 0 writes R7 ppp 000 = 0x0 and port 1 writes R7 ppp 001 = 0xFFFF_FFFF_0000_0000 -> R7 = 0xFFFF_FFFF_0000_0000.
- Scoreboard: iss R9, then read R9 next cycle -> rd_busy=1. A writeback to R9 with ppp 010 gives rd_busy=0 in that same cycle.
- Set/clear race: iss_en R4 and a write to R4 in the same cycle -> busy[R4]=1 afterwards. Invalid ppp 110 to R4 -> busy stays 1 and data is unchanged.
- Compile-out: without RF_SCOREBOARD_EN, iss R9 then read R9 -> rd_busy=0 in every cycle.
